// File: rtl/sopc_lan_bus_ctrl.sv
// Avalon-MM slave that turns CPU transfers into timed CS_n/RD_n/WR_n cycles for the LAN chip.
// Optional macro LAN_IRQ_SYNC_EN adds a 2-flop synchronizer on lan_int before avs_irq.
module sopc_lan_bus_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 1,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_chipselect,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic              avs_irq,
    input  logic              lan_enable,
    output logic              lan_cs_n,
    output logic              lan_rd_n,
    output logic              lan_wr_n,
    output logic [ADDR_W-1:0] lan_addr,
    output logic [DATA_W-1:0] lan_data_out,
    output logic              lan_data_oe,
    input  logic [DATA_W-1:0] lan_data_in,
    input  logic              lan_int
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              isWrite_q, isWrite_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              csN_q, rdN_q, wrN_q, oe_q;
    logic              req;
    logic              busActive_d;

    assign req = avs_chipselect & (avs_read | avs_write);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        isWrite_d = isWrite_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (lan_enable) begin
                        addr_d    = avs_address;
                        isWrite_d = avs_write;
                        if (avs_write) begin
                            wdata_d = avs_writedata;
                        end
                        if (SETUP_CYC != 0) begin
                            state_d = SETUP;
                            cnt_d   = SETUP_LD;
                        end else begin
                            state_d = STROBE;
                            cnt_d   = STROBE_LD;
                        end
                    end else begin
                        // Bus disabled: finish without touching the chip; reads return zero
                        state_d = DONE;
                        if (!avs_write) begin
                            rdata_d = '0;
                        end
                    end
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    if (!isWrite_q) begin
                        rdata_d = lan_data_in;
                    end
                    if (HOLD_CYC != 0) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LD;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busActive_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);

    // Pad controls are registered from the next state so they change only on clock edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            isWrite_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            csN_q     <= 1'b1;
            rdN_q     <= 1'b1;
            wrN_q     <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            isWrite_q <= isWrite_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            csN_q     <= !busActive_d;
            rdN_q     <= !((state_d == STROBE) && !isWrite_d);
            wrN_q     <= !((state_d == STROBE) && isWrite_d);
            oe_q      <= busActive_d && isWrite_d;
        end
    end

    assign avs_waitrequest = req & (state_q != DONE);
    assign avs_readdata    = rdata_q;
    assign lan_cs_n        = csN_q;
    assign lan_rd_n        = rdN_q;
    assign lan_wr_n        = wrN_q;
    assign lan_addr        = addr_q;
    assign lan_data_out    = wdata_q;
    assign lan_data_oe     = oe_q;

`ifdef LAN_IRQ_SYNC_EN
    logic [1:0] irqSync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqSync_q <= 2'b00;
        end else begin
            irqSync_q <= {irqSync_q[0], lan_int};
        end
    end

    assign avs_irq = irqSync_q[1];
`else
    assign avs_irq = lan_int;
`endif

endmodule

// File: tb/tb_sopc_lan_bus_ctrl.sv
// Self-checking bench for sopc_lan_bus_ctrl: a default-timing instance and a
// fast instance (SETUP=0, STROBE=1, HOLD=0) checked against a cycle-arithmetic model.
module tb_sopc_lan_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [0:0]  avsAddress;
   logic        chipselect0, chipselect1;
   logic        avsRead, avsWrite;
   logic [15:0] avsWritedata;
   logic        lanEnable;
   logic [15:0] lanDataIn;
   logic        lanInt;

   logic [15:0] readdata0, readdata1, dataOut0, dataOut1;
   logic        wait0, wait1, irq0, irq1;
   logic        csN0, csN1, rdN0, rdN1, wrN0, wrN1, oe0, oe1;
   logic [0:0]  addr0, addr1;

   int          assertCount = 0;
   int          failCount = 0;
   logic [15:0] lastRead [2];

   typedef struct {
      int          which;
      int          rw;
      logic [0:0]  addr;
      logic [15:0] data;
      logic [15:0] din;
      logic        en;
      int          dropAt;
      int          enFallAt;
      int          gap;
      int          expDone;
      logic [15:0] expRd;
   } vector_t;

   vector_t vectors [11];

   always #5 clk = ~clk;

   sopc_lan_bus_ctrl dutDefault (
      .clk(clk), .reset_n(reset_n),
      .avs_address(avsAddress), .avs_chipselect(chipselect0),
      .avs_read(avsRead), .avs_write(avsWrite), .avs_writedata(avsWritedata),
      .avs_readdata(readdata0), .avs_waitrequest(wait0), .avs_irq(irq0),
      .lan_enable(lanEnable), .lan_cs_n(csN0), .lan_rd_n(rdN0), .lan_wr_n(wrN0),
      .lan_addr(addr0), .lan_data_out(dataOut0), .lan_data_oe(oe0),
      .lan_data_in(lanDataIn), .lan_int(lanInt)
   );

   sopc_lan_bus_ctrl #(.SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0)) dutFast (
      .clk(clk), .reset_n(reset_n),
      .avs_address(avsAddress), .avs_chipselect(chipselect1),
      .avs_read(avsRead), .avs_write(avsWrite), .avs_writedata(avsWritedata),
      .avs_readdata(readdata1), .avs_waitrequest(wait1), .avs_irq(irq1),
      .lan_enable(lanEnable), .lan_cs_n(csN1), .lan_rd_n(rdN1), .lan_wr_n(wrN1),
      .lan_addr(addr1), .lan_data_out(dataOut1), .lan_data_oe(oe1),
      .lan_data_in(lanDataIn), .lan_int(lanInt)
   );

   // Timing parameters of each instance, used by the reference model
   function automatic int setupOf(input int which);
      return (which == 0) ? 1 : 0;
   endfunction
   function automatic int strobeOf(input int which);
      return (which == 0) ? 3 : 1;
   endfunction
   function automatic int holdOf(input int which);
      return (which == 0) ? 1 : 0;
   endfunction
   function automatic int doneOf(input int which, input logic en);
      return en ? (setupOf(which) + strobeOf(which) + holdOf(which) + 1) : 1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Bus bits packed as {cs_n, rd_n, wr_n, oe, waitrequest}
   task automatic sampleDut(input int which, output logic [4:0] bus, output logic [0:0] a,
                            output logic [15:0] dout, output logic [15:0] rdata, output logic irq);
      if (which == 0) begin
         bus = {csN0, rdN0, wrN0, oe0, wait0};
         a = addr0; dout = dataOut0; rdata = readdata0; irq = irq0;
      end else begin
         bus = {csN1, rdN1, wrN1, oe1, wait1};
         a = addr1; dout = dataOut1; rdata = readdata1; irq = irq1;
      end
   endtask

   task automatic idleCycles(input int n);
      logic [4:0]  bus;
      logic [0:0]  a;
      logic [15:0] dout, rdata;
      logic        irq;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         chipselect0 = 1'b0; chipselect1 = 1'b0; avsRead = 1'b0; avsWrite = 1'b0;
         #3;
         for (int w = 0; w < 2; w++) begin
            sampleDut(w, bus, a, dout, rdata, irq);
            checkOutput($sformatf("idle dut%0d", w), {27'd0, bus}, {27'd0, 5'b11100});
         end
      end
   endtask

   // rw: 0 = read, 1 = write, 2 = read and write together (treated as write)
   task automatic applyStimulus(input int which, input int rw, input logic [0:0] addr,
                                input logic [15:0] data, input logic [15:0] din, input logic en,
                                input int dropAt, input int enFallAt, input int expDone,
                                input logic [15:0] expRd);
      int          s, t, h;
      logic        isW, active, strobe, reqNow;
      logic [4:0]  bus, expBus;
      logic [0:0]  a;
      logic [15:0] dout, rdata;
      logic        irq;
      s = setupOf(which); t = strobeOf(which); h = holdOf(which);
      isW = (rw != 0);
      for (int k = 0; k <= expDone; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            avsAddress = addr; avsWritedata = data;
            avsRead = (rw != 1); avsWrite = (rw != 0);
            lanEnable = en;
            chipselect0 = (which == 0); chipselect1 = (which == 1);
         end
         if (k == dropAt) begin
            chipselect0 = 1'b0; chipselect1 = 1'b0;
         end
         if (k == enFallAt) lanEnable = 1'b0;
         lanDataIn = (k == s + t) ? din : ~din;
         #3;
         sampleDut(which, bus, a, dout, rdata, irq);
         active = en && (k >= 1) && (k <= s + t + h);
         strobe = en && (k >= s + 1) && (k <= s + t);
         reqNow = (k < dropAt);
         expBus = {!active, !(strobe && !isW), !(strobe && isW), active && isW, reqNow && (k != expDone)};
         checkOutput($sformatf("bus dut%0d k=%0d", which, k), {27'd0, bus}, {27'd0, expBus});
         if (active) checkOutput($sformatf("addr dut%0d k=%0d", which, k), {31'd0, a}, {31'd0, addr});
         if (active && isW) checkOutput($sformatf("dout dut%0d k=%0d", which, k), {16'd0, dout}, {16'd0, data});
         if (k == 0) checkOutput($sformatf("rdata hold dut%0d", which), {16'd0, rdata}, {16'd0, lastRead[which]});
         if (k == expDone && !isW) begin
            checkOutput($sformatf("rdata dut%0d", which), {16'd0, rdata}, {16'd0, expRd});
            lastRead[which] = expRd;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin : main
      logic [4:0]  bus;
      logic [0:0]  a;
      logic [15:0] dout, rdata;
      logic        irq;
      int          which, rw, gap, done;
      logic        en;
      logic [0:0]  rAddr;
      logic [15:0] rData, rDin, expRd;

      reset_n = 1'b0;
      avsAddress = '0; chipselect0 = 1'b0; chipselect1 = 1'b0;
      avsRead = 1'b0; avsWrite = 1'b0; avsWritedata = '0;
      lanEnable = 1'b0; lanDataIn = '0; lanInt = 1'b0;
      lastRead[0] = '0; lastRead[1] = '0;

      //              which rw addr  data      din       en  drop enFall gap done expRd
      vectors[0]  = '{0, 1, 1'b1, 16'h1234, 16'h0000, 1, 99, 99, 1, 6, 16'h0000};
      vectors[1]  = '{0, 0, 1'b0, 16'h0000, 16'hBEEF, 1, 99, 99, 1, 6, 16'hBEEF};
      vectors[2]  = '{0, 0, 1'b1, 16'h0000, 16'h4321, 0, 99, 99, 1, 1, 16'h0000};
      vectors[3]  = '{0, 1, 1'b0, 16'h9999, 16'h0000, 0, 99, 99, 1, 1, 16'h0000};
      vectors[4]  = '{1, 1, 1'b1, 16'hA5A5, 16'h0000, 1, 99, 99, 0, 2, 16'h0000};
      vectors[5]  = '{1, 1, 1'b0, 16'h5A5A, 16'h0000, 1, 99, 99, 1, 2, 16'h0000};
      vectors[6]  = '{1, 0, 1'b1, 16'h0000, 16'h0F0F, 1, 99, 99, 1, 2, 16'h0F0F};
      vectors[7]  = '{0, 2, 1'b0, 16'hCAFE, 16'h1111, 1, 99, 99, 1, 6, 16'h0000};
      vectors[8]  = '{0, 0, 1'b1, 16'h0000, 16'h7777, 1, 2,  99, 1, 6, 16'h7777};
      vectors[9]  = '{0, 1, 1'b1, 16'h2468, 16'h0000, 1, 99, 2,  1, 6, 16'h0000};
      vectors[10] = '{0, 0, 1'b0, 16'h0000, 16'h3C3C, 0, 99, 99, 1, 1, 16'h0000};

      repeat (3) @(posedge clk);
      #1;
      for (int w = 0; w < 2; w++) begin
         sampleDut(w, bus, a, dout, rdata, irq);
         checkOutput($sformatf("reset bus dut%0d", w), {27'd0, bus}, {27'd0, 5'b11100});
         checkOutput($sformatf("reset addr/data dut%0d", w), {15'd0, a, dout}, 32'd0);
         checkOutput($sformatf("reset rdata/irq dut%0d", w), {15'd0, irq, rdata}, 32'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      idleCycles(2);

      $display("[TB] table vectors");
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vectors[i].which, vectors[i].rw, vectors[i].addr, vectors[i].data,
                       vectors[i].din, vectors[i].en, vectors[i].dropAt, vectors[i].enFallAt,
                       vectors[i].expDone, vectors[i].expRd);
         if (vectors[i].gap > 0) idleCycles(vectors[i].gap);
      end

      $display("[TB] randomized accesses");
      for (int i = 0; i < 30; i++) begin
         which = $urandom_range(0, 1);
         rw    = $urandom_range(0, 2);
         rAddr = 1'($urandom_range(0, 1));
         rData = 16'($urandom);
         rDin  = 16'($urandom);
         en    = ($urandom_range(0, 3) != 0);
         gap   = $urandom_range(0, 2);
         done  = doneOf(which, en);
         expRd = (rw == 0) ? (en ? rDin : 16'h0000) : lastRead[which];
         applyStimulus(which, rw, rAddr, rData, rDin, en, 99, 99, done, expRd);
         if (gap > 0) idleCycles(gap);
      end
      idleCycles(1);

      $display("[TB] reset during strobe");
      @(posedge clk); #1;
      avsAddress = 1'b1; avsWritedata = 16'h0BAD; avsRead = 1'b0; avsWrite = 1'b1;
      lanEnable = 1'b1; chipselect0 = 1'b1; chipselect1 = 1'b0;
      repeat (3) @(posedge clk);
      #4;
      checkOutput("pre-reset wr_n", {31'd0, wrN0}, 32'd0);
      #1;
      reset_n = 1'b0;
      chipselect0 = 1'b0;
      #1;
      checkOutput("async reset strobes", {28'd0, csN0, rdN0, wrN0, oe0}, {28'd0, 4'b1110});
      checkOutput("async reset rdata", {16'd0, readdata0}, 32'd0);
      lastRead[0] = '0; lastRead[1] = '0;
      @(negedge clk);
      reset_n = 1'b1;
      idleCycles(1);
      applyStimulus(0, 0, 1'b0, 16'h0000, 16'h1357, 1, 99, 99, 6, 16'h1357);
      idleCycles(1);

      $display("[TB] interrupt path");
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         lanInt = (k < 5);
         #3;
`ifdef LAN_IRQ_SYNC_EN
         checkOutput($sformatf("irq sync k=%0d", k), {30'd0, irq0, irq1}, {30'd0, {2{(k >= 2) && (k <= 6)}}});
`else
         checkOutput($sformatf("irq pass k=%0d", k), {30'd0, irq0, irq1}, {30'd0, {2{k < 5}}});
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
